// File: rtl/pq_pkg.sv
// Shared types for priority-queue devices and their clients.
// A key of all ones (KEYINF) marks an empty slot and is never stored.
package pq_pkg;

  localparam int KEY_W       = 16;
  localparam int VAL_W       = 16;
  localparam int PQ_CAPACITY = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam logic [KEY_W-1:0] KEYINF = '1;
  localparam logic [VAL_W-1:0] VAL0   = '0;

endpackage

// File: rtl/pq_sort_client.sv
// Batch sorter built on any pq_if priority queue.
// LOAD pushes a valid/ready input stream into the PQ until in_last or PQ full,
// DRAIN pops the PQ head straight onto a valid/ready output stream (min key first),
// DONE emits a one-cycle batch_done pulse before accepting the next batch.
// enq and deq are never issued together, so the PQ replace path is never exercised.
module pq_sort_client
  import pq_pkg::*;
#(
  parameter int CNT_W = $clog2(PQ_CAPACITY + 1)
) (
  input  logic clk,
  input  logic rst,
  // producer side
  input  logic in_valid,
  output logic in_ready,
  input  kv_t  in_kv,
  input  logic in_last,
  // consumer side
  output logic out_valid,
  input  logic out_ready,
  output kv_t  out_kv,
  output logic out_last,
  // status pulses
  output logic batch_done,
  output logic overflow,
  output logic drop_err,
  // PQ device side
  output logic pq_enq,
  output logic pq_deq,
  output kv_t  pq_kvi,
  input  kv_t  pq_kvo,
  input  logic pq_full,
  input  logic pq_empty,
  input  logic pq_busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;

  // Handshake outputs and next state; everything is a direct function of the
  // current state and the PQ flags so the output path has zero latency.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_kv     = pq_kvo;
    batch_done = 1'b0;
    overflow   = 1'b0;
    drop_err   = 1'b0;
    pq_enq     = 1'b0;
    pq_deq     = 1'b0;
    pq_kvi     = '{key: KEYINF, val: VAL0};

    if (!rst) begin
      unique case (state_q)
        S_LOAD: begin
          in_ready = !pq_full && !pq_busy;
          if (in_valid && in_ready) begin
            if (in_kv.key == KEYINF) begin
              // An infinite key would read as an empty slot inside the PQ.
              drop_err = 1'b1;
            end else begin
              pq_enq = 1'b1;
              pq_kvi = in_kv;
              cnt_d  = cnt_q + CNT_W'(1);
            end
            if (in_last) begin
              state_d = (cnt_d == '0) ? S_DONE : S_DRAIN;
            end
          end else if (pq_full && (cnt_q != '0)) begin
            // PQ filled before the producer closed the batch: sort what we have.
            overflow = 1'b1;
            state_d  = S_DRAIN;
          end
        end

        S_DRAIN: begin
          // A PQ that reports empty while items are still owed is a fault; hold.
          out_valid = !pq_empty && !pq_busy && (cnt_q != '0);
          out_last  = out_valid && (cnt_q == CNT_W'(1));
          pq_deq    = out_valid && out_ready;
          if (pq_deq) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end

        S_DONE: begin
          batch_done = 1'b1;
          state_d    = S_LOAD;
        end

        default: state_d = S_LOAD;
      endcase
    end
  end

  // State and occupancy registers; the PQ is cleared by the same reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Protocol guarantees towards the PQ device.
  a_no_replace : assert property (@(posedge clk) disable iff (rst) !(pq_enq && pq_deq));
  a_busy_idle  : assert property (@(posedge clk) disable iff (rst) pq_busy |-> !(pq_enq || pq_deq));

endmodule
